// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Holds the responder FSM encoding, bus widths and the address range helper.
package dmem_pkg;

    localparam int BE_W   = 4;
    localparam int DATA_W = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // A byte address is outside the RAM when any bit above the word index is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_w);
        return ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// MEM-stage load/store request bus: valid/ready request, one-cycle response pulse.
interface dmem_resp_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port data RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset; rdata only changes on an enabled read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rdata_r;

    // Byte-lane write or full-word registered read on an enabled cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, optional wait states,
// commits byte-masked stores and returns a one-cycle response pulse.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_resp_if.slave  bus
);

    localparam bit              HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [WAIT_W-1:0] CNT_LOAD = HAS_WAIT ? WAIT_W'(WAIT_CYCLES - 1) : {WAIT_W{1'b0}};

    state_e              state_r, state_s;
    logic [WAIT_W-1:0]   cnt_r, cnt_s;
    logic                ready_r;
    logic                accept_s;
    logic                enter_resp_s;

    logic                we_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [BE_W-1:0]     be_r;
    logic                oor_r;

    logic                use_latch_s;
    logic                op_we_s;
    logic [ADDR_W-1:0]   op_idx_s;
    logic [DATA_W-1:0]   op_wdata_s;
    logic [BE_W-1:0]     op_be_s;
    logic                op_oor_s;
    logic                ram_en_s;
    logic [DATA_W-1:0]   ram_rdata_s;

    logic                rsp_valid_r;
    logic                rsp_err_r;
    logic                rsp_load_r;

    assign accept_s = bus.req_valid && bus.req_ready;

    // Next-state and wait-counter logic; RESP behaves like IDLE for a new accept.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                if (accept_s) begin
                    if (HAS_WAIT) begin
                        state_s = WAIT;
                        cnt_s   = CNT_LOAD;
                    end else begin
                        state_s      = RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {WAIT_W{1'b0}}) begin
                    state_s      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - WAIT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {WAIT_W{1'b0}};
            end
        endcase
    end

    // FSM state, wait counter and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {WAIT_W{1'b0}};
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s != WAIT);
        end
    end

    // Request latch, captured on every accept for use after the wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            idx_r   <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            be_r    <= {BE_W{1'b0}};
            oor_r   <= 1'b0;
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            idx_r   <= bus.req_addr[ADDR_W+1:2];
            wdata_r <= bus.req_wdata;
            be_r    <= bus.req_be;
            oor_r   <= addr_out_of_range(bus.req_addr, ADDR_W);
        end
    end

    // With no wait states the RAM access happens on the accept edge itself,
    // so the live request feeds the RAM; otherwise the latched copy does.
    assign use_latch_s = (state_r == WAIT);
    assign op_we_s     = use_latch_s ? we_r    : bus.req_we;
    assign op_idx_s    = use_latch_s ? idx_r   : bus.req_addr[ADDR_W+1:2];
    assign op_wdata_s  = use_latch_s ? wdata_r : bus.req_wdata;
    assign op_be_s     = use_latch_s ? be_r    : bus.req_be;
    assign op_oor_s    = use_latch_s ? oor_r   : addr_out_of_range(bus.req_addr, ADDR_W);

    // rst_n gating keeps a reset that coincides with the RESP-entry edge from writing.
    assign ram_en_s = enter_resp_s && !op_oor_s && rst_n;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (op_we_s),
        .be    (op_be_s),
        .addr  (op_idx_s),
        .wdata (op_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Response pulse, error flag and load/store marker for the data mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_load_r  <= 1'b0;
        end else begin
            rsp_valid_r <= enter_resp_s;
            rsp_err_r   <= enter_resp_s && op_oor_s;
            if (enter_resp_s) begin
                rsp_load_r <= !op_we_s && !op_oor_s;
            end
        end
    end

    assign bus.req_ready = ready_r && rst_n;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_load_r ? ram_rdata_s : {DATA_W{1'b0}};
    assign bus.busy      = (state_r == WAIT) || ((state_r == RESP) && accept_s);

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances with 0, 3 and 2 wait states.
module tb_dmem_resp;

    logic clk;
    logic rst0_n, rst3_n, rst2_n;
    int   n_checks;
    int   n_fail;

    dmem_resp_if bus0 ();
    dmem_resp_if bus3 ();
    dmem_resp_if bus2 ();

    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0.slave));
    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3.slave));
    dmem_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d; bus0.req_be = be;
    endtask

    task automatic drive3(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus3.req_valid = v; bus3.req_we = we; bus3.req_addr = a; bus3.req_wdata = d; bus3.req_be = be;
    endtask

    task automatic drive2(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = a; bus2.req_wdata = d; bus2.req_be = be;
    endtask

    task automatic test_reset;
        rst0_n = 1'b0; rst3_n = 1'b0; rst2_n = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive3(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.busy, bus0.rsp_rdata} !== 36'h0) begin
            n_fail++; $display("FAIL reset_hold_bus0: got %h expected %h",
                {bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.busy, bus0.rsp_rdata}, 36'h0);
        end
        n_checks++;
        if ({bus3.req_ready, bus3.rsp_valid, bus3.rsp_err, bus3.busy, bus3.rsp_rdata} !== 36'h0) begin
            n_fail++; $display("FAIL reset_hold_bus3: got %h expected %h",
                {bus3.req_ready, bus3.rsp_valid, bus3.rsp_err, bus3.busy, bus3.rsp_rdata}, 36'h0);
        end
        rst0_n = 1'b1; rst3_n = 1'b1; rst2_n = 1'b1;
        #1;
        n_checks++;
        if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.busy, bus0.rsp_rdata} !== {4'b1000, 32'h0}) begin
            n_fail++; $display("FAIL reset_release_bus0: got %h expected %h",
                {bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.busy, bus0.rsp_rdata}, {4'b1000, 32'h0});
        end
        n_checks++;
        if ({bus2.req_ready, bus2.busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release_bus2: got %b expected %b", {bus2.req_ready, bus2.busy}, 2'b10);
        end
    endtask

    task automatic test_store_load;
        @(negedge clk); drive0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        n_checks++;
        if ({bus0.req_ready, bus0.busy} !== 2'b10) begin
            n_fail++; $display("FAIL idle_ready_busy: got %b expected %b", {bus0.req_ready, bus0.busy}, 2'b10);
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata} !== {2'b10, 32'h0}) begin
            n_fail++; $display("FAIL store_rsp: got %h expected %h", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b10, 32'h0});
        end
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        n_checks++;
        if ({bus0.req_ready, bus0.busy} !== 2'b11) begin
            n_fail++; $display("FAIL resp_accept_busy: got %b expected %b", {bus0.req_ready, bus0.busy}, 2'b11);
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL b2b_load_rsp: got %h expected %h", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b10, 32'hDEADBEEF});
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.busy, bus0.rsp_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rdata_hold: got %h expected %h", {bus0.rsp_valid, bus0.busy, bus0.rsp_rdata}, {2'b00, 32'hDEADBEEF});
        end
    endtask

    task automatic test_byte_mask;
        @(negedge clk); drive0(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF);
        @(negedge clk); drive0(1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        @(negedge clk); drive0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata} !== {2'b10, 32'h11BB33DD}) begin
            n_fail++; $display("FAIL byte_mask_merge: got %h expected %h", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b10, 32'h11BB33DD});
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_out_of_range;
        @(negedge clk); drive0(1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
        @(negedge clk); drive0(1'b1, 1'b1, 32'h00001000, 32'hAAAAAAAA, 4'hF);
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL oor_store_rsp: got %h expected %h", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b11, 32'h0});
        end
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata} !== {2'b10, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL oor_word0_intact: got %h expected %h", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b10, 32'hCAFEF00D});
        end
        drive0(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL oor_load_rsp: got %h expected %h", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b11, 32'h0});
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_be_zero;
        @(negedge clk); drive0(1'b1, 1'b1, 32'h40, 32'h01020304, 4'hF);
        @(negedge clk); drive0(1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err} !== 2'b10) begin
            n_fail++; $display("FAIL be0_ack: got %b expected %b", {bus0.rsp_valid, bus0.rsp_err}, 2'b10);
        end
        drive0(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata} !== {2'b10, 32'h01020304}) begin
            n_fail++; $display("FAIL be0_data_unchanged: got %h expected %h", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {2'b10, 32'h01020304});
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Accept at edge N: ready low and busy high in N+1..N+3, single pulse in N+4.
    task automatic test_wait_states;
        logic [31:0] exp_rdata;
        for (int pass = 0; pass < 2; pass++) begin
            exp_rdata = (pass == 0) ? 32'h0 : 32'h00C0FFEE;
            @(negedge clk); drive3(1'b1, (pass == 0), 32'h50, 32'h00C0FFEE, 4'hF);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                n_checks++;
                if ({bus3.rsp_valid, bus3.req_ready} !== {(k == 4), (k >= 4)}) begin
                    n_fail++; $display("FAIL wait3_valid_ready pass%0d cycle N+%0d: got %b expected %b",
                        pass, k, {bus3.rsp_valid, bus3.req_ready}, {(k == 4), (k >= 4)});
                end
                if (k != 4) begin
                    n_checks++;
                    if (bus3.busy !== (k <= 3)) begin
                        n_fail++; $display("FAIL wait3_busy pass%0d cycle N+%0d: got %b expected %b", pass, k, bus3.busy, (k <= 3));
                    end
                end else begin
                    n_checks++;
                    if ({bus3.rsp_err, bus3.rsp_rdata} !== {1'b0, exp_rdata}) begin
                        n_fail++; $display("FAIL wait3_rsp pass%0d: got %h expected %h", pass, {bus3.rsp_err, bus3.rsp_rdata}, {1'b0, exp_rdata});
                    end
                end
                if (k == 1) begin
                    drive3(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        logic got;
        @(negedge clk); drive2(1'b1, 1'b1, 32'h30, 32'h12345678, 4'hF);
        @(negedge clk); drive2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        drive2(1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        drive2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst2_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, bus2.busy, bus2.rsp_rdata} !== 36'h0) begin
                n_fail++; $display("FAIL midwait_reset_outs step%0d: got %h expected %h", k,
                    {bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, bus2.busy, bus2.rsp_rdata}, 36'h0);
            end
            @(negedge clk);
        end
        rst2_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus2.req_ready, bus2.rsp_valid, bus2.busy} !== 3'b100) begin
                n_fail++; $display("FAIL midwait_no_rsp step%0d: got %b expected %b", k, {bus2.req_ready, bus2.rsp_valid, bus2.busy}, 3'b100);
            end
        end
        drive2(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        @(negedge clk); drive2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus2.rsp_valid === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if ({bus2.rsp_err, bus2.rsp_rdata} !== {1'b0, 32'h12345678}) begin
                    n_fail++; $display("FAIL midwait_word_intact: got %h expected %h", {bus2.rsp_err, bus2.rsp_rdata}, {1'b0, 32'h12345678});
                end
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL midwait_load_timeout: got no rsp_valid expected one within 8 cycles");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_store_load();
        test_byte_mask();
        test_out_of_range();
        test_be_zero();
        test_wait_states();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
